// File: rtl/seq_shift_alu.sv
// Clocked 8-op ALU with valid/ready handshakes on both sides.
// Shifts run one bit per cycle through a working register, so no barrel shifter is needed.
module seq_shift_alu #(
   parameter  int WIDTH = 16,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] outp,
   output logic             cout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_SRA = 3'b111;

   // Single-cycle ops; result is {carry, value}.
   function automatic logic [WIDTH:0] alu_f(input logic [2:0] f_op,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
      logic [WIDTH:0] r;
      r = {(WIDTH+1){1'b0}};
      case (f_op)
         OP_ADD:  r = {1'b0, a} + {1'b0, b};
         OP_SUB:  r = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
         OP_AND:  r = {1'b0, a & b};
         OP_OR:   r = {1'b0, a | b};
         OP_XOR:  r = {1'b0, a ^ b};
         default: r = {1'b0, a};
      endcase
      return r;
   endfunction

   // One-bit shift step; result is {bit shifted out, shifted value}.
   function automatic logic [WIDTH:0] step_f(input logic [2:0] f_op,
                                             input logic [WIDTH-1:0] w);
      logic [WIDTH:0] r;
      r = {1'b0, w};
      case (f_op)
         OP_SHL:  r = {w[WIDTH-1], w[WIDTH-2:0], 1'b0};
         OP_SHR:  r = {w[0], 1'b0, w[WIDTH-1:1]};
         OP_SRA:  r = {w[0], w[WIDTH-1], w[WIDTH-1:1]};
         default: r = {1'b0, w};
      endcase
      return r;
   endfunction

   function automatic logic is_shift_f(input logic [2:0] f_op);
      return f_op[2] & (f_op[1] | f_op[0]);
   endfunction

   state_t           state_r,     state_s;
   logic [2:0]       op_r,        op_s;
   logic [WIDTH-1:0] work_r,      work_s;
   logic [SHW-1:0]   cnt_r,       cnt_s;
   logic [WIDTH-1:0] outp_r,      outp_s;
   logic             cout_r,      cout_s;
   logic             out_valid_r, out_valid_s;
   logic             in_ready_r,  in_ready_s;
   logic [WIDTH:0]   alu_s;
   logic [WIDTH:0]   step_s;

   // Next-state and next-output decode for the handshake/shift FSM.
   always_comb begin
      state_s     = state_r;
      op_s        = op_r;
      work_s      = work_r;
      cnt_s       = cnt_r;
      outp_s      = outp_r;
      cout_s      = cout_r;
      out_valid_s = out_valid_r;
      in_ready_s  = in_ready_r;
      alu_s       = alu_f(op, i0, i1);
      step_s      = step_f(op_r, work_r);
      case (state_r)
         IDLE: begin
            if (in_valid && in_ready_r) begin
               op_s       = op;
               in_ready_s = 1'b0;
               if (!is_shift_f(op)) begin
                  outp_s      = alu_s[WIDTH-1:0];
                  cout_s      = alu_s[WIDTH];
                  out_valid_s = 1'b1;
                  state_s     = DONE;
               end else if (i1[SHW-1:0] == {SHW{1'b0}}) begin
                  outp_s      = i0;
                  cout_s      = 1'b0;
                  out_valid_s = 1'b1;
                  state_s     = DONE;
               end else begin
                  work_s  = i0;
                  cnt_s   = i1[SHW-1:0];
                  state_s = SHIFT;
               end
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            work_s = step_s[WIDTH-1:0];
            cnt_s  = cnt_r - SHW'(1);
            // <= also catches a zero count, so the FSM can never spin through a wrap.
            if (cnt_r <= SHW'(1)) begin
               cnt_s       = {SHW{1'b0}};
               outp_s      = step_s[WIDTH-1:0];
               cout_s      = step_s[WIDTH];
               out_valid_s = 1'b1;
               state_s     = DONE;
            end else begin
               state_s = SHIFT;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_s = 1'b0;
               in_ready_s  = 1'b1;
               state_s     = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            out_valid_s = 1'b0;
            in_ready_s  = 1'b1;
            cnt_s       = {SHW{1'b0}};
            state_s     = IDLE;
         end
      endcase
   end

   // State, operand and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         op_r        <= 3'b000;
         work_r      <= {WIDTH{1'b0}};
         cnt_r       <= {SHW{1'b0}};
         outp_r      <= {WIDTH{1'b0}};
         cout_r      <= 1'b0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
      end else begin
         state_r     <= state_s;
         op_r        <= op_s;
         work_r      <= work_s;
         cnt_r       <= cnt_s;
         outp_r      <= outp_s;
         cout_r      <= cout_s;
         out_valid_r <= out_valid_s;
         in_ready_r  <= in_ready_s;
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign outp      = outp_r;
   assign cout      = cout_r;

endmodule

// File: tb/tb_seq_shift_alu.sv
// Directed bench for seq_shift_alu: opcode results, shift latency,
// backpressure and mid-operation reset, with hand-computed expectations.
module tb_seq_shift_alu;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [2:0]   op = 3'b000;
   logic [W-1:0] i0 = 16'h0000;
   logic [W-1:0] i1 = 16'h0000;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] outp;
   logic         cout;

   int checks = 0;
   int failures = 0;

   seq_shift_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .i0        (i0),
      .i1        (i1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .outp      (outp),
      .cout      (cout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Present one op for a single accept edge, then scramble inputs.
   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      in_valid = 1'b1;
      op = o;
      i0 = a;
      i1 = b;
      @(negedge clk);
      in_valid = 1'b0;
      op = ~o;
      i0 = ~a;
      i1 = ~b;
   endtask

   // Counts accept-to-valid latency; busy goes 0 if in_ready is seen high meanwhile.
   task automatic wait_valid(output int lat, output logic busy);
      lat = 1;
      busy = !in_ready;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
         if (in_ready) busy = 1'b0;
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eo, input logic ec,
                         input int el);
      int   lat;
      logic busy;
      issue(o, a, b);
      wait_valid(lat, busy);
      chk({tag, "_outp"}, 32'(outp), 32'(eo));
      chk({tag, "_cout"}, 32'(cout), 32'(ec));
      chk({tag, "_lat"}, 32'(lat), 32'(el));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_vdrop"}, 32'(out_valid), 32'd0);
      chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int   lat;
      logic busy;
      logic ok;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_outp", 32'(outp), 32'h0000);
      chk("rst_cout", 32'(cout), 32'd0);
      rst_n = 1'b1;

      run_op("add", 3'b000, 16'hcb7f, 16'h0013, 16'hcb92, 1'b0, 1);
      run_op("sub", 3'b001, 16'hcb7f, 16'h0013, 16'hcb6c, 1'b1, 1);
      run_op("and", 3'b010, 16'hcb7f, 16'h0013, 16'h0013, 1'b0, 1);
      run_op("or",  3'b011, 16'hcb7f, 16'h0013, 16'hcb7f, 1'b0, 1);
      run_op("xor", 3'b100, 16'hcb7f, 16'h0013, 16'hcb6c, 1'b0, 1);
      run_op("shl3", 3'b101, 16'hcb7f, 16'h0013, 16'h5bf8, 1'b0, 4);
      run_op("shr3", 3'b110, 16'hcb7f, 16'h0013, 16'h196f, 1'b1, 4);
      run_op("sra3", 3'b111, 16'hcb7f, 16'h0013, 16'hf96f, 1'b1, 4);
      run_op("add_c", 3'b000, 16'hcb7f, 16'h6fff, 16'h3b7e, 1'b1, 1);
      run_op("shl15", 3'b101, 16'hcb7f, 16'h6fff, 16'h8000, 1'b1, 16);
      run_op("shl0", 3'b101, 16'hcb7f, 16'h0010, 16'hcb7f, 1'b0, 1);

      // Hold the xor result under backpressure while in_valid toggles.
      issue(3'b100, 16'hcb7f, 16'h0013);
      wait_valid(lat, busy);
      chk("bp_lat", 32'(lat), 32'd1);
      ok = 1'b1;
      for (int n = 0; n < 10; n++) begin
         in_valid = ~in_valid;
         op = 3'b000;
         i0 = 16'h0001;
         i1 = 16'h0001;
         @(negedge clk);
         if (outp !== 16'hcb6c || cout !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0)
            ok = 1'b0;
      end
      in_valid = 1'b0;
      chk("bp_stable", 32'(ok), 32'd1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_vdrop", 32'(out_valid), 32'd0);
      chk("bp_rdy", 32'(in_ready), 32'd1);
      repeat (3) @(negedge clk);
      chk("bp_noqueue_valid", 32'(out_valid), 32'd0);
      chk("bp_noqueue_outp", 32'(outp), 32'hcb6c);

      // Reset in the middle of a 15-bit shift.
      issue(3'b101, 16'hcb7f, 16'h6fff);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_outp", 32'(outp), 32'h0000);
      chk("mid_rst_cout", 32'(cout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ok = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (out_valid !== 1'b0 || in_ready !== 1'b1) ok = 1'b0;
      end
      chk("mid_rst_no_result", 32'(ok), 32'd1);
      run_op("post_rst_add", 3'b000, 16'h0001, 16'hffff, 16'h0000, 1'b1, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
